// File: rtl/cmos_frame_sequencer_pkg.sv
// Shared definitions for the CMOS capture path: sequencer states,
// default frame geometry and coordinate widths.
package cmos_frame_sequencer_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_ACTIVE,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/cmos_byte_pairer.sv
// Pairs camera bytes into 16-bit pixels. The byte phase is cleared whenever
// HREF is low, so every line starts on the high byte.
module cmos_byte_pairer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        href_i,
  input  logic [7:0]  byte_i,
  output logic        phase_o,
  output logic        pair_fire_o,
  output logic [15:0] pair_word_o
);

  logic       phase_q, phase_d;
  logic [7:0] hi_q, hi_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    phase_d = 1'b0;
    hi_d    = hi_q;
    if (en_i && href_i) begin
      phase_d = ~phase_q;
      if (!phase_q) hi_d = byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignment so all flops update from pre-edge values.
    if (!rst_n) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

  // Second byte of the pair is the one being sampled on this edge.
  assign phase_o     = phase_q;
  assign pair_fire_o = en_i & href_i & phase_q;
  assign pair_word_o = {hi_q, byte_i};

endmodule

// File: rtl/cmos_frame_sequencer.sv
// Frame/line sequencer: qualifies the byte stream with VSYNC/HREF, strobes
// pixels with coordinates and a linear write address, and flips the ping-pong bank.
module cmos_frame_sequencer
  import cmos_frame_sequencer_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic              CMOS_oCLK,
  input  logic              iRST_N,
  input  logic              enable,
  input  logic              CMOS_VSYNC,
  input  logic              CMOS_HREF,
  input  logic [7:0]        DATA,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_start,
  output logic              frame_done,
  output logic              frame_err,
  output logic              pp_bank
);

  localparam logic [X_W-1:0]    X_FULL    = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  seq_state_e        state_q, state_d;
  logic              vs_q, href_q;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
  logic              err_q, err_d;

  logic [15:0]       pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic [X_W-1:0]    pix_x_q, pix_x_d;
  logic [Y_W-1:0]    pix_y_q, pix_y_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic              pp_bank_q, pp_bank_d;

  logic        capture_en, phase, pair_fire;
  logic [15:0] pair_word;
  logic        vs_rise, vs_fall, href_fall;

  assign capture_en = (state_q == ST_ACTIVE);
  assign vs_rise    = ~vs_q & CMOS_VSYNC;
  assign vs_fall    = vs_q & ~CMOS_VSYNC;
  assign href_fall  = href_q & ~CMOS_HREF;

  cmos_byte_pairer u_pairer (
    .clk         (CMOS_oCLK),
    .rst_n       (iRST_N),
    .en_i        (capture_en),
    .href_i      (CMOS_HREF),
    .byte_i      (DATA),
    .phase_o     (phase),
    .pair_fire_o (pair_fire),
    .pair_word_o (pair_word)
  );

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    base_d        = base_q;
    err_d         = err_q;
    pix_data_d    = pix_data_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    wr_addr_d     = wr_addr_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    pp_bank_d     = pp_bank_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (vs_fall) begin
          state_d       = ST_ACTIVE;
          frame_start_d = 1'b1;
          x_d           = '0;
          y_d           = '0;
          addr_d        = '0;
          base_d        = '0;
          err_d         = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (pair_fire) begin
          if (x_q != X_FULL) begin
            pix_valid_d = 1'b1;
            pix_data_d  = pair_word;
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            wr_addr_d   = addr_q;
            x_d         = x_q + 1'b1;
            addr_d      = addr_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        // Address is rebased per line so a short line cannot skew later rows.
        if (href_fall) begin
          err_d  = err_q | phase | (x_q != X_FULL);
          x_d    = '0;
          y_d    = y_q + 1'b1;
          base_d = base_q + LINE_STEP;
          addr_d = base_q + LINE_STEP;
        end
        if (href_fall && (y_q == Y_LAST)) begin
          state_d = ST_DONE;
          if (err_d) begin
            frame_err_d = 1'b1;
          end else begin
            frame_done_d = 1'b1;
            pp_bank_d    = ~pp_bank_q;
          end
        end else if (vs_rise) begin
          frame_err_d = 1'b1;
          state_d     = enable ? ST_WAIT_VS : ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = enable ? ST_WAIT_VS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CMOS_oCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q       <= ST_IDLE;
      vs_q          <= 1'b0;
      href_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      base_q        <= '0;
      err_q         <= 1'b0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      wr_addr_q     <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      pp_bank_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= CMOS_VSYNC;
      href_q        <= CMOS_HREF;
      x_q           <= x_d;
      y_q           <= y_d;
      addr_q        <= addr_d;
      base_q        <= base_d;
      err_q         <= err_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      wr_addr_q     <= wr_addr_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      pp_bank_q     <= pp_bank_d;
    end
  end

  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign wr_addr     = wr_addr_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign pp_bank     = pp_bank_q;

endmodule

// File: tb/tb_cmos_frame_sequencer.sv
// Bench for cmos_frame_sequencer on a 4x3 frame: table of frame scenarios plus
// hand sequences for mid-line reset and enable drop; pixels checked via a scoreboard.
module tb_cmos_frame_sequencer;
  import cmos_frame_sequencer_pkg::*;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           rst_n, en, vs, href;
  logic [7:0]     data;
  logic [15:0]    pix_data;
  logic           pix_valid;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic [AW-1:0]  wr_addr;
  logic           frame_start, frame_done, frame_err, pp_bank;

  cmos_frame_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .CMOS_oCLK   (clk),
    .iRST_N      (rst_n),
    .enable      (en),
    .CMOS_VSYNC  (vs),
    .CMOS_HREF   (href),
    .DATA        (data),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .wr_addr     (wr_addr),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .pp_bank     (pp_bank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          x;
    int          y;
    int          addr;
  } pix_exp_t;

  typedef struct {
    int len0, len1, len2;
    int nlines;
    int salt;
    bit drop_en;
    int exp_pix;
    bit exp_done;
    bit exp_err;
    bit exp_bank;
  } frame_vec_t;

  pix_exp_t    sb[$];
  int          n_checks = 0, n_pass = 0;
  int          n_start = 0, n_done = 0, n_err = 0, n_pix = 0;
  logic [15:0] first_pix = '0, last_pix = '0;
  bit          want_first = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin : monitor
    pix_exp_t e;
    if (frame_start) begin
      n_start++;
      want_first = 1'b1;
    end
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (frame_done || frame_err) check("done_err_exclusive", 32'(frame_done & frame_err), 32'd0);
    if (pix_valid) begin
      n_pix++;
      last_pix = pix_data;
      if (want_first) begin
        first_pix  = pix_data;
        want_first = 1'b0;
      end
      check("pix_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pix_data", 32'(pix_data), 32'(e.data));
        check("pix_x", 32'(pix_x), 32'(e.x));
        check("pix_y", 32'(pix_y), 32'(e.y));
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
      end
    end
  end

  task automatic tick(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk);
    vs   = v;
    href = h;
    data = d;
  endtask

  task automatic vs_pulse();
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
  endtask

  // Drives one line of bytes; expected pixels are pushed for in-range pairs only.
  task automatic send_line(input int y, input int nbytes, input int salt);
    logic [7:0] prev, d;
    pix_exp_t   e;
    prev = '0;
    for (int b = 0; b < nbytes; b++) begin
      d = 8'((salt + y * 2 * H + b) & 255);
      if ((b % 2 == 1) && (b / 2 < H)) begin
        e.data = {prev, d};
        e.x    = b / 2;
        e.y    = y;
        e.addr = y * H + b / 2;
        sb.push_back(e);
      end
      tick(1'b0, 1'b1, d);
      prev = d;
    end
  endtask

  task automatic run_frame(input frame_vec_t v, input string tag);
    int s0, d0, e0, p0;
    int lens[3];
    lens = '{v.len0, v.len1, v.len2};
    s0 = n_start; d0 = n_done; e0 = n_err; p0 = n_pix;
    vs_pulse();
    for (int y = 0; y < v.nlines; y++) begin
      send_line(y, lens[y], v.salt);
      if (y == 0 && v.drop_en) en = 1'b0;
      tick(1'b0, 1'b0, 8'h00);
      if (y == V - 1) begin
        @(negedge clk);
        check({tag, ":done_pulse"}, 32'(frame_done), 32'(v.exp_done));
        check({tag, ":err_pulse"}, 32'(frame_err), 32'(v.exp_err));
      end
      tick(1'b0, 1'b0, 8'h00);
    end
    if (v.nlines < V) begin
      tick(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      check({tag, ":abort_err"}, 32'(frame_err), 32'd1);
      check({tag, ":abort_state"}, 32'(dut.state_q == ST_WAIT_VS), 32'd1);
      repeat (3) tick(1'b1, 1'b0, 8'h00);
    end else begin
      repeat (3) tick(1'b0, 1'b0, 8'h00);
    end
    check({tag, ":starts"}, 32'(n_start - s0), 32'd1);
    check({tag, ":dones"}, 32'(n_done - d0), 32'(v.exp_done));
    check({tag, ":errs"}, 32'(n_err - e0), 32'(v.exp_err));
    check({tag, ":pix_count"}, 32'(n_pix - p0), 32'(v.exp_pix));
    check({tag, ":pp_bank"}, 32'(pp_bank), 32'(v.exp_bank));
    check({tag, ":sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    frame_vec_t vecs[7];
    frame_vec_t post;
    int s0, d0, e0, p0;

    //          len0 len1 len2 lines salt drop pix done err bank
    vecs[0] = '{8,   8,   8,   3,    0,   0,   12,  1,   0,  1};
    vecs[1] = '{8,   8,   8,   3,    32,  0,   12,  1,   0,  0};
    vecs[2] = '{8,   7,   8,   3,    64,  0,   11,  0,   1,  0};
    vecs[3] = '{8,   8,   0,   2,    96,  0,   8,   0,   1,  0};
    vecs[4] = '{8,   8,   8,   3,    128, 0,   12,  1,   0,  1};
    vecs[5] = '{10,  8,   8,   3,    160, 0,   12,  0,   1,  1};
    vecs[6] = '{8,   6,   8,   3,    192, 0,   11,  0,   1,  1};

    rst_n = 1'b0; en = 1'b0; vs = 1'b0; href = 1'b0; data = 8'h00;
    repeat (2) @(negedge clk);
    check("reset:pix_valid", 32'(pix_valid), 32'd0);
    check("reset:pix_data", 32'(pix_data), 32'd0);
    check("reset:coords", 32'({pix_y, pix_x, wr_addr}), 32'd0);
    check("reset:pulses", 32'({frame_start, frame_done, frame_err}), 32'd0);
    check("reset:pp_bank", 32'(pp_bank), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        check("vec0:first_pix", 32'(first_pix), 32'h0001);
        check("vec0:last_pix", 32'(last_pix), 32'h1617);
      end
    end

    // Reset pulse in the middle of line 1.
    vs_pulse();
    send_line(0, 8, 16);
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    send_line(1, 3, 16);
    @(negedge clk);
    check("midrst:sb_drained", 32'(sb.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst:pix_valid", 32'(pix_valid), 32'd0);
    check("midrst:pix_data", 32'(pix_data), 32'd0);
    check("midrst:coords", 32'({pix_y, pix_x, wr_addr}), 32'd0);
    check("midrst:pulses", 32'({frame_start, frame_done, frame_err}), 32'd0);
    check("midrst:pp_bank", 32'(pp_bank), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = n_start; d0 = n_done; e0 = n_err; p0 = n_pix;
    for (int b = 3; b < 8; b++) tick(1'b0, 1'b1, 8'(b));
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    for (int b = 0; b < 8; b++) tick(1'b0, 1'b1, 8'(8'h80 + b));
    repeat (3) tick(1'b0, 1'b0, 8'h00);
    check("midrst:no_pulses", 32'((n_start - s0) + (n_done - d0) + (n_err - e0)), 32'd0);
    check("midrst:no_pix", 32'(n_pix - p0), 32'd0);
    post = '{8, 8, 8, 3, 64, 0, 12, 1, 0, 1};
    run_frame(post, "post_rst");

    // Enable dropped during line 0: frame finishes, then capture stays idle.
    post = '{8, 8, 8, 3, 80, 1, 12, 1, 0, 0};
    run_frame(post, "en_drop");
    s0 = n_start; p0 = n_pix;
    vs_pulse();
    for (int b = 0; b < 8; b++) tick(1'b0, 1'b1, 8'(b));
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    vs_pulse();
    repeat (3) tick(1'b0, 1'b0, 8'h00);
    check("en_drop:no_start", 32'(n_start - s0), 32'd0);
    check("en_drop:no_pix", 32'(n_pix - p0), 32'd0);
    check("en_drop:idle", 32'(dut.state_q == ST_IDLE), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmos_frame_sequencer.md
# cmos_frame_sequencer

Frame/line sequencer for the CMOS capture path. It qualifies the camera byte stream with CMOS_VSYNC/CMOS_HREF, pairs bytes into 16-bit pixels with a per-line-aligned byte phase, and tracks pixel and line coordinates. It produces a single-cycle pixel strobe with a linear write address for the downstream Gaussian stage and the ping-pong frame RAM, and sequences the ping-pong bank. It replaces the free-running divided Gaussian clock with a clock enable in the CMOS_oCLK domain.

## Interface
- H_ACTIVE, 640, active pixels (byte pairs) per line
- V_ACTIVE, 480, active lines per frame
- ADDR_W, 19, width of wr_addr; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- CMOS_oCLK  in  1  pixel-byte clock; the only clock
- iRST_N  in  1  reset, asynchronous and active-low
- enable  in  1  capture enable, sampled only in IDLE and at frame boundaries
- CMOS_VSYNC  in  1  frame sync, active-high blanking
- CMOS_HREF  in  1  line valid, high while bytes are valid
- DATA  in  8  camera byte
- pix_data  out  16  {first byte, second byte} of the completed pair
- pix_valid  out  1  one-cycle strobe, pix_data/pix_x/pix_y/wr_addr valid
- pix_x  out  10  column of the strobed pixel
- pix_y  out  9  row of the strobed pixel
- wr_addr  out  ADDR_W  pix_y*H_ACTIVE + pix_x (incrementing counter, no multiplier)
- frame_start  out  1  pulse on first active edge of a frame
- frame_done  out  1  pulse after the last pixel of a good frame
- frame_err  out  1  pulse when a frame is aborted or malformed
- pp_bank  out  1  bank being written; the consumer reads ~pp_bank

## Operation
- States: IDLE, WAIT_VS, ACTIVE, DONE.
- IDLE: stays here while enable=0. With enable=1, goes to WAIT_VS.
- WAIT_VS: waits for a CMOS_VSYNC falling edge (registered VSYNC 1 then 0). Then goes to ACTIVE, pulses frame_start, and clears x, y, addr and the error flag.
- ACTIVE:
  - With HREF=1 the byte phase toggles on every edge. Phase 0 latches the high byte. Phase 1 completes the pair and strobes pix_valid.
  - The byte phase is forced to 0 while HREF=0, so every line starts on the high byte.
  - On HREF falling edge: if phase was 1 (odd byte count) or the pixel count is not H_ACTIVE, set the sticky line error. Then y increments and x clears.
  - Pixels beyond H_ACTIVE in a line and lines beyond V_ACTIVE produce no pix_valid. Over-length lines also set the error.
- Going to DONE when the V_ACTIVE-th line ends (HREF falls with y = V_ACTIVE-1).
- DONE, one cycle:
  - Error flag clear: frame_done pulses and pp_bank toggles.
  - Error flag set: frame_err pulses and pp_bank holds.
  - Then goes to WAIT_VS if enable=1, else IDLE.
- VSYNC rising in ACTIVE before V_ACTIVE lines complete (short frame): frame_err pulses, pp_bank holds, and the block goes to WAIT_VS. No frame_done.
- enable falling in ACTIVE: the current frame finishes normally, then the block goes to IDLE.

## Timing
- All outputs are registered. Reset values: pix_data=0, pix_valid=0, pix_x=0, pix_y=0, wr_addr=0, frame_start=0, frame_done=0, frame_err=0, pp_bank=0. State resets to IDLE.
- Latency: pix_valid is high in the cycle after the edge that samples the second byte. Sustained rate is at most one strobe per 2 cycles.
- frame_done/frame_err occur in the cycle after the terminating HREF fall or VSYNC rise.
- frame_done and frame_err are mutually exclusive. At most one of them fires per frame_start.
- If HREF falls on the same edge that samples the second byte, the pixel is still strobed before the line closes.
- If VSYNC rises on the edge that ends line V_ACTIVE-1, frame_done takes priority.
- Reset mid-frame: everything returns to reset values immediately. No pulses are emitted.

## Structure
- Shared capture package: state encoding (IDLE/WAIT_VS/ACTIVE/DONE), H_ACTIVE/V_ACTIVE defaults, and the coordinate widths.
- One natural sub-module: cmos_byte_pairer, containing the byte phase, high-byte latch and pair strobe, with HREF as the phase clear.
- The FSM, counters, address and bank logic stay in the top level.

## Test plan
- Reset, then enable=1 and a 4x3 frame (H_ACTIVE=4, V_ACTIVE=3) with bytes 0x00..0x17:
  - 12 pix_valid, first pix_data=0x0001, last pix_data=0x1617.
  - wr_addr runs 0..11, pix_x wraps 0..3, pix_y runs 0..2.
  - One frame_start, one frame_done, pp_bank becomes 1.
- Two back-to-back good frames: pp_bank goes 0→1→0, and wr_addr restarts at 0 after each frame_start.
- Line 1 carries 7 bytes (odd count):
  - Line 1's last byte is not strobed, and line 2 still starts on the high byte.
  - End of frame gives frame_err=1, no frame_done, pp_bank unchanged.
- VSYNC rises after 2 of 3 lines: frame_err pulses one cycle later, state returns to WAIT_VS, and the next full frame completes normally.
- iRST_N low for one cycle mid-line: all outputs are 0 that cycle, no pulses follow, and capture waits for the next VSYNC fall.
- enable dropped mid-frame: the frame completes with frame_done, then no further frame_start despite further VSYNC pulses.
